pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk is the single clock; rst is asynchronous and active-low.
REQ-002 Port clk  in  1  pipeline clock.
REQ-003 Port rst  in  1  asynchronous, active-low reset.
REQ-004 Port jump_flag_i  in  1  EX-stage redirect request.
REQ-005 Port jump_addr_i  in  32  EX-stage redirect target.
REQ-006 Port hold_flag_ex_i  in  1  EX busy with a multi-cycle op (div).
REQ-007 Port hold_flag_rib_i  in  1  bus arbiter holding the core.
REQ-008 Port hold_flag_clint_i  in  1  interrupt controller holding the core.
REQ-009 Port id_rs1_raddr_i / id_rs2_raddr_i  in  5 each  ID source register addresses.
REQ-010 Port id_rs1_re_i / id_rs2_re_i  in  1 each  ID source read enables.
REQ-011 Port idex_reg_waddr_i  in  5  destination of the instruction now in ID/EX.
REQ-012 Port idex_reg_we_i  in  1  ID/EX writes a register.
REQ-013 Port idex_is_load_i  in  1  ID/EX holds a load.
REQ-014 Port hold_flag_o  out  3  flush level to PC/IF_ID/ID_EX.
REQ-015 Port stall_pc_o / stall_ifid_o / stall_idex_o  out  1 each  keep-contents stalls.
REQ-016 Port jump_flag_o  out  1  redirect to PC register.
REQ-017 Port jump_addr_o  out  32  redirect target.
REQ-018 Port stall_cycles_o  out  32  count of cycles with any stall asserted.
REQ-019 Port flush_count_o  out  16  count of jump-caused flushes.
REQ-020 Shared constants: Hold_None 3'b000, Hold_Pc 3'b001, Hold_If 3'b010, Hold_Id 3'b011.

Function
REQ-021 The FSM SHALL have states RUN, LU_STALL and EX_BUSY.
REQ-022 Load-use hazard (lu) SHALL be: idex_is_load_i & idex_reg_we_i & idex_reg_waddr_i!=0 & ((id_rs1_re_i & rs1==waddr) | (id_rs2_re_i & rs2==waddr)).
REQ-023 Output priority per cycle SHALL be: jump > EX busy > clint > rib > lu.
REQ-024 On jump_flag_i: same cycle, jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=Hold_Id, all stalls 0; next state RUN; flush_count_o increments by 1 (wraps at 16'hFFFF).
REQ-025 On hold_flag_ex_i (no jump): stall_pc_o=stall_ifid_o=stall_idex_o=1, hold_flag_o=Hold_None; state EX_BUSY while asserted, RUN on the cycle after deassertion.
REQ-026 On hold_flag_clint_i (no higher event): hold_flag_o=Hold_Id, stalls 0.
REQ-027 On hold_flag_rib_i (no higher event): hold_flag_o=Hold_Pc, stall_ifid_o=stall_idex_o=1.
REQ-028 lu in RUN (no higher event): stall_pc_o=stall_ifid_o=1, stall_idex_o=0, hold_flag_o=Hold_Id (bubble into ID/EX); next state LU_STALL.
REQ-029 LU_STALL SHALL last exactly one cycle; lu is ignored in LU_STALL; next state is RUN unless a higher-priority event applies.
REQ-030 Idle (no event): hold_flag_o=Hold_None, all stalls 0, jump_flag_o=0, jump_addr_o=0.
REQ-031 stall_cycles_o SHALL increment in every cycle where any stall_*_o is 1, wrapping at 32'hFFFFFFFF.
REQ-032 All hold/stall/jump outputs SHALL be combinational from inputs and state; latency 0 cycles.

Reset
REQ-033 rst low SHALL asynchronously set state=RUN, stall_cycles_o=0, flush_count_o=0; combinational outputs then follow idle/priority rules.
REQ-034 Reset asserted mid-EX_BUSY or mid-LU_STALL SHALL return state to RUN immediately, with no counter update in that cycle.

Structure
REQ-035 Hold_* encodings and the FSM state encoding SHALL reside in the shared defines package.
REQ-036 The hazard comparator SHALL be one sub-module, hazard_detect (purely combinational, outputs lu).

Verification
REQ-037 ID/EX load x5, ID reads rs1=x5 -> 1 cycle: stall_pc_o=stall_ifid_o=1, hold_flag_o=3; next cycle idle; stall_cycles_o=1.
REQ-038 Load writing x0, ID reads x0 -> no stall; stall_cycles_o unchanged.
REQ-039 jump_flag_i=1 with jump_addr_i=0x00000100 simultaneous with lu -> jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3, stalls 0; flush_count_o=1.
REQ-040 hold_flag_ex_i high 4 cycles -> all three stalls high 4 cycles; stall_cycles_o=4; RUN on the 5th cycle.
REQ-041 Preload flush_count_o=16'hFFFF, then one jump -> flush_count_o=0.
REQ-042 rst pulsed low during EX_BUSY -> state RUN, counters 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for pipeline control: flush levels and controller FSM states.
// Constants only; no logic.
package pipe_ctrl_pkg;

   localparam logic [2:0] Hold_None = 3'b000;
   localparam logic [2:0] Hold_Pc   = 3'b001;
   localparam logic [2:0] Hold_If   = 3'b010;
   localparam logic [2:0] Hold_Id   = 3'b011;

   localparam logic [4:0] REG_ZERO  = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      EX_BUSY  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator between the ID sources and the ID/EX load destination.
// Purely combinational, 0 cycles; no backpressure.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_raddr,
   input  logic [4:0] rs2_raddr,
   input  logic       rs1_re,
   input  logic       rs2_re,
   input  logic [4:0] waddr,
   input  logic       we,
   input  logic       is_load,
   output logic       lu
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = rs1_re & (rs1_raddr == waddr);
   assign rs2_hit = rs2_re & (rs2_raddr == waddr);
   // x0 is never a real dependency, so a load targeting it cannot cause a hazard
   assign lu      = is_load & we & (waddr != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritises jump/EX-busy/clint/rib/load-use into flush and stall controls.
// Outputs combinational (0 cycles) from inputs and state; stalls are the backpressure it issues.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_ex_i,
   input  logic        hold_flag_rib_i,
   input  logic        hold_flag_clint_i,
   input  logic [4:0]  id_rs1_raddr_i,
   input  logic [4:0]  id_rs2_raddr_i,
   input  logic        id_rs1_re_i,
   input  logic        id_rs2_re_i,
   input  logic [4:0]  idex_reg_waddr_i,
   input  logic        idex_reg_we_i,
   input  logic        idex_is_load_i,
   output logic [2:0]  hold_flag_o,
   output logic        stall_pc_o,
   output logic        stall_ifid_o,
   output logic        stall_idex_o,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic [31:0] stall_cycles_o,
   output logic [15:0] flush_count_o
);

   state_t state_q;
   state_t state_d;
   logic   lu;
   logic   stall_any;

   hazard_detect u_hazard_detect (
      .rs1_raddr (id_rs1_raddr_i),
      .rs2_raddr (id_rs2_raddr_i),
      .rs1_re    (id_rs1_re_i),
      .rs2_re    (id_rs2_re_i),
      .waddr     (idex_reg_waddr_i),
      .we        (idex_reg_we_i),
      .is_load   (idex_is_load_i),
      .lu        (lu)
   );

   always_comb begin
      state_d      = RUN;
      hold_flag_o  = Hold_None;
      stall_pc_o   = 1'b0;
      stall_ifid_o = 1'b0;
      stall_idex_o = 1'b0;
      jump_flag_o  = 1'b0;
      jump_addr_o  = '0;
      if (jump_flag_i) begin
         jump_flag_o = 1'b1;
         jump_addr_o = jump_addr_i;
         hold_flag_o = Hold_Id;
      end else if (hold_flag_ex_i) begin
         stall_pc_o   = 1'b1;
         stall_ifid_o = 1'b1;
         stall_idex_o = 1'b1;
         state_d      = EX_BUSY;
      end else if (hold_flag_clint_i) begin
         hold_flag_o = Hold_Id;
      end else if (hold_flag_rib_i) begin
         hold_flag_o  = Hold_Pc;
         stall_ifid_o = 1'b1;
         stall_idex_o = 1'b1;
      end else if (lu && (state_q != LU_STALL)) begin
         // freeze PC and IF/ID while a bubble enters ID/EX; the load then resolves in one cycle
         stall_pc_o   = 1'b1;
         stall_ifid_o = 1'b1;
         hold_flag_o  = Hold_Id;
         state_d      = LU_STALL;
      end
   end

   assign stall_any = stall_pc_o | stall_ifid_o | stall_idex_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= RUN;
         stall_cycles_o <= '0;
         flush_count_o  <= '0;
      end else begin
         state_q <= state_d;
         if (stall_any) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
         end
         if (jump_flag_i) begin
            flush_count_o <= flush_count_o + 16'd1;
         end
      end
   end

endmodule
